hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Producer-side register-write tracker for the pipeline; complements the EX-stage forwarding unit.
// - Marks destination registers pending when an instruction issues from ID and clears them at writeback.
// - Raises a stall when an issuing instruction reads, or would over-subscribe, a pending register.
// - Sits in ID beside the register file. Its stall output gates the PC/IF_ID write enables and inserts a bubble into ID_EX.
// PARAMETERS
// - NUM_REGS, 32: architectural registers. x0 is never tracked.
// - REG_AW, 5: register index width, equal to clog2(NUM_REGS).
// - CNT_W, 2: per-register in-flight write counter width. The counter saturates at 2**CNT_W-1.
// PORTS
// - clk             in   1       clock, rising edge
// - reset           in   1       synchronous, active-high
// - issue_valid     in   1       the instruction in ID is attempting to issue
// - issue_rs1       in   REG_AW  source register 1
// - issue_rs2       in   REG_AW  source register 2
// - issue_use_rs1   in   1       rs1 is actually read
// - issue_use_rs2   in   1       rs2 is actually read
// - issue_regwrite  in   1       the instruction writes rd
// - issue_is_load   in   1       the instruction is a load
// - issue_rd        in   REG_AW  destination register
// - wb_valid        in   1       MEM_WB retires a register write this cycle
// - wb_rd           in   REG_AW  register being written back
// - kill_valid      in   1       a squashed in-flight instruction releases its rd (branch flush)
// - kill_rd         in   REG_AW  rd of the squashed instruction
// - stall           out  1       hold IF/ID and bubble ID_EX
// - pending_mask    out  NUM_REGS  bit r is set when count[r] != 0
// - sb_err          out  1       sticky: a release arrived for a register whose count was 0
// BEHAVIOUR
// - Tracked set:
//   - With SB_LOAD_ONLY_EN: only issues with issue_is_load are tracked.
//   - Without it: every issue_regwrite is tracked.
//   - rd == 0 is never tracked.
// - inc = issue_valid & ~stall & tracked & (issue_rd != 0).
// - Releases: wb_valid or kill_valid with a nonzero rd decrements that register, provided the instruction was tracked.
//   - In SB_LOAD_ONLY_EN mode the pipeline qualifies wb_valid to loads only.
// - Per-register next count = count + inc_r - wb_r - kill_r. Net zero leaves the count unchanged.
//   - wb_rd == kill_rd on the same cycle decrements by 2.
// - Underflow: a release on a count of 0 leaves the count at 0 and sets sb_err on the next edge. sb_err clears only on reset.
// - eff_pend(r) = (count[r] - wb_r - kill_r) > 0, using this cycle's releases.
//   - A writeback in the same cycle therefore clears the hazard. The register file is write-first.
// - stall is combinational (0 cycles of latency) and equals issue_valid & ~reset & one of:
//   - issue_use_rs1 & eff_pend(rs1), or
//   - issue_use_rs2 & eff_pend(rs2), or
//   - tracked rd with count[rd] == 2**CNT_W-1 (saturation; the increment is refused).
// - Stalled issues do not increment. No state machine; all state lives in the counters plus sb_err.
// - pending_mask is registered state and reflects the counts at the start of the cycle.
// - Reset: all counts 0, pending_mask 0, sb_err 0. stall is 0 while reset is high.
//   - Issue, wb and kill inputs are ignored during reset.
// - Reset mid-operation discards all in-flight tracking. The pipeline must flush together with this block.
// CONFIGURATION
// - SB_LOAD_ONLY_EN defined: load-use interlock only. ALU results rely on the forwarding unit.
//   - A load followed immediately by a consumer stalls until that load's writeback.
// - SB_LOAD_ONLY_EN undefined: full interlock for builds without forwarding.
//   - Every RAW hazard on a tracked rd stalls until writeback.
// TESTING
// - Reset, then idle -> stall=0, pending_mask=0, sb_err=0.
// - Issue a load x5. Next cycle issue add with rs1=x5 -> stall=1 each cycle until wb_valid,wb_rd=5. stall=0 in the wb cycle; pending_mask[5] clears on the next edge.
// - Issue a tracked write to x0, then a reader of x0 -> no count change, stall=0.
// - With CNT_W=2, issue 3 writes to x7 with no wb -> 4th issue to x7 gets stall=1. A wb of x7 in the same cycle still stalls; the next cycle's issue is accepted.
// - Same-cycle issue rd=9 and wb_rd=9 with count=1 -> count stays 1. kill_rd=9 next cycle -> count 0, pending_mask[9]=0.
// - wb_valid, wb_rd=12 with count 0 -> sb_err=1 and it holds until reset. Assert reset with counts nonzero -> all cleared the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Issue/writeback/kill bundle between the ID-stage pipeline control and the hazard scoreboard.
// The pipeline drives the master side; the scoreboard is the slave.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5
);
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs1;
    logic [REG_AW-1:0] issue_rs2;
    logic              issue_use_rs1;
    logic              issue_use_rs2;
    logic              issue_regwrite;
    logic              issue_is_load;
    logic [REG_AW-1:0] issue_rd;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              kill_valid;
    logic [REG_AW-1:0] kill_rd;
    logic                stall;
    logic [NUM_REGS-1:0] pending_mask;
    logic                sb_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_regwrite, issue_is_load, issue_rd,
               wb_valid, wb_rd, kill_valid, kill_rd,
        input  stall, pending_mask, sb_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_regwrite, issue_is_load, issue_rd,
               wb_valid, wb_rd, kill_valid, kill_rd,
        output stall, pending_mask, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write counters with a combinational RAW/saturation stall.
// Optional macro SB_LOAD_ONLY_EN: track loads only (load-use interlock beside a forwarding unit).
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  sb
);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [SUM_W-1:0]    rel   [NUM_REGS];
    logic [SUM_W-1:0]    sum   [NUM_REGS];
    logic [NUM_REGS-1:0] eff_pend;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                err_q, err_d;
    logic                tracked, rd_nz, sat, stall_c, inc;
    logic                unused_ok;

`ifdef SB_LOAD_ONLY_EN
    assign tracked   = sb.issue_is_load;
    assign unused_ok = &{1'b0, sb.issue_regwrite};
`else
    assign tracked   = sb.issue_regwrite;
    assign unused_ok = &{1'b0, sb.issue_is_load};
`endif

    // Releases from this cycle are folded into the hazard check (write-first register file).
    always_comb begin
        rd_nz    = (sb.issue_rd != '0);
        sat      = tracked && rd_nz && (cnt_q[sb.issue_rd] == CNT_MAX);
        eff_pend = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            rel[r] = SUM_W'(sb.wb_valid   && (sb.wb_rd   == REG_AW'(r)) && (r != 0))
                   + SUM_W'(sb.kill_valid && (sb.kill_rd == REG_AW'(r)) && (r != 0));
            eff_pend[r] = (SUM_W'(cnt_q[r]) > rel[r]);
        end
        stall_c = sb.issue_valid && !reset &&
                  ((sb.issue_use_rs1 && eff_pend[sb.issue_rs1]) ||
                   (sb.issue_use_rs2 && eff_pend[sb.issue_rs2]) ||
                   sat);
        inc = sb.issue_valid && !stall_c && tracked && rd_nz;
    end

    // Next counts; a release that exceeds what is in flight clamps to zero and flags an error.
    always_comb begin
        err_d  = err_q;
        pend_d = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            sum[r] = SUM_W'(cnt_q[r]) + SUM_W'(inc && (sb.issue_rd == REG_AW'(r)));
            if (sum[r] < rel[r]) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum[r] - rel[r]);
            end
            pend_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '{default: '0};
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign sb.stall        = stall_c;
    assign sb.pending_mask = pend_q;
    assign sb.sb_err       = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then randomized traffic against an integer model.
module tb_hazard_scoreboard;
    localparam int NR      = 32;
    localparam int AW      = 5;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NR), .REG_AW(AW)) sb_if ();
    hazard_scoreboard #(.NUM_REGS(NR), .REG_AW(AW), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    typedef struct {
        logic          stall;
        logic [NR-1:0] mask;
        logic          err;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt[NR];
    bit   err_m = 1'b0;

    task automatic idle();
        sb_if.issue_valid    = 1'b0;
        sb_if.issue_rs1      = '0;
        sb_if.issue_rs2      = '0;
        sb_if.issue_use_rs1  = 1'b0;
        sb_if.issue_use_rs2  = 1'b0;
        sb_if.issue_regwrite = 1'b0;
        sb_if.issue_is_load  = 1'b0;
        sb_if.issue_rd       = '0;
        sb_if.wb_valid       = 1'b0;
        sb_if.wb_rd          = '0;
        sb_if.kill_valid     = 1'b0;
        sb_if.kill_rd        = '0;
    endtask

    task automatic issue(input int rd, input bit load, input int rs1, input bit u1,
                         input int rs2, input bit u2);
        sb_if.issue_valid    = 1'b1;
        sb_if.issue_rd       = AW'(rd);
        sb_if.issue_is_load  = load;
        sb_if.issue_regwrite = 1'b1;
        sb_if.issue_rs1      = AW'(rs1);
        sb_if.issue_use_rs1  = u1;
        sb_if.issue_rs2      = AW'(rs2);
        sb_if.issue_use_rs2  = u2;
    endtask

    // Model: predict this cycle's outputs from the current inputs, then advance to the next edge.
    task automatic tick(input string tag);
        exp_t e;
        int   rl[NR];
        bit   trk, st, inc;
        int   rd, n;
`ifdef SB_LOAD_ONLY_EN
        trk = sb_if.issue_is_load;
`else
        trk = sb_if.issue_regwrite;
`endif
        rd = int'(sb_if.issue_rd);
        for (int r = 0; r < NR; r++) begin
            rl[r] = 0;
            if (r != 0 && sb_if.wb_valid   && int'(sb_if.wb_rd)   == r) rl[r]++;
            if (r != 0 && sb_if.kill_valid && int'(sb_if.kill_rd) == r) rl[r]++;
        end
        st = sb_if.issue_valid && !reset &&
             ((sb_if.issue_use_rs1 && (cnt[sb_if.issue_rs1] - rl[sb_if.issue_rs1] > 0)) ||
              (sb_if.issue_use_rs2 && (cnt[sb_if.issue_rs2] - rl[sb_if.issue_rs2] > 0)) ||
              (trk && rd != 0 && cnt[rd] == CNT_MAX));
        e.stall = st;
        for (int r = 0; r < NR; r++) e.mask[r] = (cnt[r] != 0);
        e.err = err_m;
        e.tag = tag;
        exp_q.push_back(e);
        if (reset) begin
            for (int r = 0; r < NR; r++) cnt[r] = 0;
            err_m = 1'b0;
        end else begin
            inc = sb_if.issue_valid && !st && trk && rd != 0;
            for (int r = 0; r < NR; r++) begin
                n = cnt[r] + ((inc && r == rd) ? 1 : 0) - rl[r];
                if (n < 0) begin
                    n = 0;
                    err_m = 1'b1;
                end
                cnt[r] = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        idle();
        reset = 1'b1;
        tick(tag);
        reset = 1'b0;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (sb_if.stall !== e.stall) begin
                    errors++;
                    $display("FAIL %s stall: got %0b want %0b", e.tag, sb_if.stall, e.stall);
                end
                checks++;
                if (sb_if.pending_mask !== e.mask) begin
                    errors++;
                    $display("FAIL %s pending_mask: got %h want %h", e.tag, sb_if.pending_mask, e.mask);
                end
                checks++;
                if (sb_if.sb_err !== e.err) begin
                    errors++;
                    $display("FAIL %s sb_err: got %0b want %0b", e.tag, sb_if.sb_err, e.err);
                end
            end
        end
    end

    initial begin
        int live[$];
        int w, k, wait_cnt;
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");
        idle();
        tick("idle0");
        tick("idle1");

        // Load-use: consumer stalls until the load's writeback cycle.
        issue(5, 1'b1, 0, 1'b0, 0, 1'b0);
        tick("load_x5");
        issue(6, 1'b0, 5, 1'b1, 0, 1'b0);
        repeat (3) tick("use_x5_stall");
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = AW'(5);
        tick("use_x5_wb");
        idle();
        tick("x5_cleared");
        do_reset("reset_a");

        // x0 is never tracked.
        issue(0, 1'b1, 0, 1'b0, 0, 1'b0);
        tick("write_x0");
        issue(3, 1'b0, 0, 1'b1, 0, 1'b1);
        tick("read_x0");
        idle();
        tick("x0_idle");
        do_reset("reset_b");

        // Saturation of x7.
        issue(7, 1'b1, 0, 1'b0, 0, 1'b0);
        repeat (3) tick("x7_fill");
        tick("x7_sat");
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = AW'(7);
        tick("x7_sat_wb");
        sb_if.wb_valid = 1'b0;
        tick("x7_accept");
        idle();
        tick("x7_idle");
        do_reset("reset_c");

        // Net-zero issue/wb, then kill release.
        issue(9, 1'b1, 0, 1'b0, 0, 1'b0);
        tick("x9_issue");
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = AW'(9);
        tick("x9_netzero");
        idle();
        tick("x9_hold");
        sb_if.kill_valid = 1'b1;
        sb_if.kill_rd    = AW'(9);
        tick("x9_kill");
        idle();
        tick("x9_clear");

        // Underflow is sticky until reset; reset clears nonzero counts.
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = AW'(12);
        tick("x12_underflow");
        idle();
        repeat (3) tick("err_sticky");
        issue(4, 1'b1, 0, 1'b0, 0, 1'b0);
        tick("fill_x4");
        issue(8, 1'b1, 0, 1'b0, 0, 1'b0);
        tick("fill_x8");
        do_reset("reset_busy");
        idle();
        tick("after_reset");

        // Randomized traffic; releases target only registers with something in flight.
        for (int i = 0; i < 3000; i++) begin
            idle();
            if ($urandom_range(0, 99) < 70) begin
                sb_if.issue_valid    = 1'b1;
                sb_if.issue_rs1      = AW'($urandom_range(0, 7));
                sb_if.issue_rs2      = AW'($urandom_range(0, 7));
                sb_if.issue_use_rs1  = 1'($urandom_range(0, 1));
                sb_if.issue_use_rs2  = 1'($urandom_range(0, 1));
                sb_if.issue_regwrite = 1'($urandom_range(0, 1));
                sb_if.issue_is_load  = 1'($urandom_range(0, 1));
                sb_if.issue_rd       = AW'($urandom_range(0, 7));
            end
            live.delete();
            for (int r = 1; r < NR; r++) if (cnt[r] > 0) live.push_back(r);
            w = -1;
            if (live.size() > 0 && $urandom_range(0, 99) < 45) begin
                w = live[$urandom_range(0, live.size() - 1)];
                sb_if.wb_valid = 1'b1;
                sb_if.wb_rd    = AW'(w);
            end
            if (live.size() > 0 && $urandom_range(0, 99) < 15) begin
                k = live[$urandom_range(0, live.size() - 1)];
                if (k != w || cnt[k] >= 2) begin
                    sb_if.kill_valid = 1'b1;
                    sb_if.kill_rd    = AW'(k);
                end
            end
            if ($urandom_range(0, 999) < 5) reset = 1'b1;
            tick("random");
            reset = 1'b0;
        end

        idle();
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
